l2_dmem_rd_streamer: RTL and testbench

- Read-side initiator for an L2 dmem rd port (core or dma): turns one descriptor (base, stride, length) into a sequence of 256-bit line reads.
- Issues read requests on the req/gnt handshake and collects in-order responses on the valid/ready handshake.
- Buffers responses and presents them as a downstream valid/ready stream with a last marker.
- Used by DMA/loader logic that streams L2 lines out of the tile.

---
 rtl/l2_dmem_pkg.sv | 26 ++
 rtl/l2_rd_resp_fifo.sv | 61 ++++++
 rtl/l2_dmem_rd_streamer.sv | 156 +++++++++++++++
 tb/tb_l2_dmem_rd_streamer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_dmem_pkg.sv
// Shared widths, FSM encoding and descriptor layout for the L2 dmem read streamer.
package l2_dmem_pkg;
  localparam int ADDR_W       = 11;
  localparam int DATA_W       = 256;
  localparam int LEN_W        = 10;
  localparam int L2_MAX_OUTST = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } st_e;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [LEN_W-1:0]  len;
  } desc_t;

  // Line address arithmetic wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] s);
    return a + s;
  endfunction
endpackage

// File: rtl/l2_rd_resp_fifo.sv
// Small synchronous FIFO holding L2 read responses until the stream side pops them.
module l2_rd_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_fire, rd_fire;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign wr_fire = push_i & ~full_o;
  assign rd_fire = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_fire) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({wr_fire, rd_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/l2_dmem_rd_streamer.sv
// Descriptor-driven L2 line reader: issues credited reads, buffers in-order
// responses and replays them as a valid/ready stream tagged with a last marker.
module l2_dmem_rd_streamer
  import l2_dmem_pkg::*;
#(
  parameter int MAX_OUTST = L2_MAX_OUTST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int OCC_W = $clog2(MAX_OUTST) + 1;

  st_e               state_q, state_d;
  desc_t             cmd_desc;
  logic [ADDR_W-1:0] stride_q, addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, issued_q, issued_d, returned_q, returned_d, popped_q, popped_d;
  logic [OCC_W-1:0]  occ_q, occ_d, fifo_cnt;
  logic              err_q, err_d;
  logic              cmd_acc, gnt_fire, pop, inflight, push, stray;
  logic              fifo_full, fifo_empty;

  assign cmd_desc = '{base: cmd_base, stride: cmd_stride, len: cmd_len};

  assign cmd_acc  = cmd_valid & cmd_ready;
  assign gnt_fire = rd_req & rd_gnt;
  assign pop      = out_valid & out_ready;
  assign inflight = (issued_q != returned_q);
  // A beat with nothing outstanding is dropped rather than buffered.
  assign push     = rd_valid & rd_ready & inflight;
  assign stray    = rd_valid & ~inflight;

  assign rd_addr   = addr_q;
  assign rd_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign out_last  = out_valid & (popped_q == len_q - 1'b1);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_acc) state_d = (cmd_desc.len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (gnt_fire && (issued_q + 1'b1 == len_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rd_req    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = ~rst;
        busy      = 1'b0;
      end
      ST_ISSUE: rd_req = (occ_q < OCC_W'(MAX_OUTST)) && (issued_q < len_q);
      ST_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    popped_d   = popped_q;
    err_d      = err_q | stray;
    if (cmd_acc) begin
      addr_d     = cmd_desc.base;
      issued_d   = '0;
      returned_d = '0;
      popped_d   = '0;
      err_d      = stray;
    end else begin
      if (gnt_fire) begin
        addr_d   = addr_step(addr_q, stride_q);
        issued_d = issued_q + 1'b1;
      end
      if (push) returned_d = returned_q + 1'b1;
      if (pop)  popped_d   = popped_q + 1'b1;
    end
    unique case ({gnt_fire, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      popped_q   <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cmd_acc) begin
        stride_q <= cmd_desc.stride;
        len_q    <= cmd_desc.len;
      end
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      popped_q   <= popped_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
    end
  end

  l2_rd_resp_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (rd_data),
    .pop_i   (pop),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Everything buffered was granted and not yet popped, so it is covered by occ.
  a_occ_covers_fifo: assert property (@(posedge clk) disable iff (rst) fifo_cnt <= occ_q);
endmodule

// File: tb/tb_l2_dmem_rd_streamer.sv
// Scoreboard bench: L2 responder with latency 1, expected addresses/data queued at issue time.
module tb_l2_dmem_rd_streamer;
  import l2_dmem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_base, cmd_stride;
  logic [LEN_W-1:0]  cmd_len;
  logic              rd_req, rd_gnt, rd_valid, rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data, out_data;
  logic              out_valid, out_last, out_ready, busy, done, err;

  l2_dmem_rd_streamer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input logic [10:0] a, input int seq);
    logic [15:0] s;
    s = 16'(seq);
    return {8{{a, 5'b0}, s}};
  endfunction

  logic [ADDR_W-1:0] addr_exp[$];
  logic [255:0]      data_q[$];
  int   grants = 0, beats = 0, done_cnt = 0, cyc = 0, beat_idx = 0, cur_len = 0;
  int   first_cyc = 0, last_cyc = 0;
  logic pend = 1'b0, stray_req = 1'b0, chk_done_next = 1'b0;
  logic [255:0] pend_data;

  // L2 responder and stream monitor, both evaluated mid-cycle.
  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b0; rd_valid = 1'b0; chk_done_next = 1'b0; beat_idx = 0;
        addr_exp.delete(); data_q.delete();
      end else begin
        if (chk_done_next) begin chk("done_after_last", done, 1); chk_done_next = 1'b0; end
        rd_valid = pend | stray_req;
        rd_data  = pend ? pend_data : '1;
        if (pend) chk("rd_ready_on_resp", rd_ready, 1);
        pend = 1'b0;
        if (rd_req && rd_gnt) begin
          if (addr_exp.size() == 0) chk("unexpected_grant", 1, 0);
          else chk("rd_addr", rd_addr, addr_exp.pop_front());
          pend_data = mkdata(rd_addr, grants);
          data_q.push_back(pend_data);
          pend = 1'b1;
          grants++;
        end
        if (out_valid && out_ready) begin
          if (data_q.size() == 0) chk("unexpected_beat", 1, 0);
          else chk("out_data", out_data, data_q.pop_front());
          chk("out_last", out_last, beat_idx == cur_len - 1);
          if (beat_idx == 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
          if (beat_idx == cur_len - 1) begin beat_idx = 0; chk_done_next = 1'b1; end
          else beat_idx++;
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic send(input logic [10:0] b, input logic [10:0] s, input int l, input bit push_addrs);
    logic [10:0] a;
    bit ok;
    a = b;
    cur_len = l;
    if (push_addrs) for (int i = 0; i < l; i++) begin addr_exp.push_back(a); a = a + s; end
    cmd_valid = 1'b1; cmd_base = b; cmd_stride = s; cmd_len = LEN_W'(l);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 400 && done_cnt == d0; k++) @(posedge clk);
    #1;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 200 && grants < n; k++) begin @(posedge clk); #1; end
    if (grants < n) chk("grant_timeout", grants, n);
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_rd_req"}, rd_req, 0);
    chk({t, "_rd_addr"}, rd_addr, 0);
    chk({t, "_rd_ready"}, rd_ready, 1);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_out_last"}, out_last, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_err"}, err, 0);
    chk({t, "_cmd_ready"}, cmd_ready, 1);
  endtask

  int g0, b0;
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0;
    rd_gnt = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_reset_vals("reset");

    // Streaming at full rate
    rd_gnt = 1'b1; out_ready = 1'b1; b0 = beats;
    send(11'h010, 11'd1, 8, 1'b1);
    wait_done();
    chk("t1_beats", beats - b0, 8);
    chk("t1_rate", last_cyc - first_cyc, 7);
    chk("t1_err", err, 0);
    chk("t1_done_pulse", done, 0);
    chk("t1_cmd_ready_after", cmd_ready, 1);
    chk("t1_sb_empty", data_q.size(), 0);

    // Backpressure: credits cap outstanding lines
    out_ready = 1'b0; g0 = grants; b0 = beats;
    send(11'h010, 11'd1, 8, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("t2_grants_capped", grants - g0, 4);
    chk("t2_req_low", rd_req, 0);
    chk("t2_rd_ready_full", rd_ready, 0);
    out_ready = 1'b1;
    wait_done();
    chk("t2_grants_total", grants - g0, 8);
    chk("t2_beats", beats - b0, 8);
    chk("t2_sb_empty", data_q.size(), 0);

    // Address wrap
    addr_exp.push_back(11'h7FE); addr_exp.push_back(11'h001); addr_exp.push_back(11'h004);
    send(11'h7FE, 11'd3, 3, 1'b0);
    wait_done();
    chk("t3_addr_q_empty", addr_exp.size(), 0);

    // Grant withheld on second request
    g0 = grants;
    send(11'h100, 11'd2, 4, 1'b1);
    wait_grants(g0 + 1);
    rd_gnt = 1'b0;
    repeat (5) begin
      #1;
      chk("t4_req_held", rd_req, 1);
      chk("t4_addr_stable", rd_addr, 11'h102);
      chk("t4_no_issue", grants - g0, 1);
      @(posedge clk); #1;
    end
    rd_gnt = 1'b1;
    wait_done();
    chk("t4_grants", grants - g0, 4);

    // Zero-length descriptor
    g0 = grants;
    send(11'h055, 11'd1, 0, 1'b1);
    chk("t5_done", done, 1);
    chk("t5_cmd_ready_done", cmd_ready, 0);
    chk("t5_no_req", rd_req, 0);
    @(posedge clk); #1;
    chk("t5_done_gone", done, 0);
    chk("t5_cmd_ready_idle", cmd_ready, 1);
    chk("t5_no_grants", grants - g0, 0);

    // Reset mid-transfer, then a stray response
    g0 = grants;
    send(11'h200, 11'd1, 8, 1'b1);
    wait_grants(g0 + 3);
    rst = 1'b1;
    #1;
    chk("t6_cmd_ready_in_rst", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_reset_vals("t6");
    stray_req = 1'b1;
    @(posedge clk); #1;
    stray_req = 1'b0;
    chk("t6_err_set", err, 1);
    @(posedge clk); #1;
    chk("t6_err_sticky", err, 1);
    chk("t6_stray_dropped", out_valid, 0);
    send(11'h300, 11'd1, 1, 1'b1);
    chk("t6_err_cleared", err, 0);
    wait_done();
    chk("t6_sb_empty", data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
